// File: rtl/bit_pack_fifo.sv
// Packs a serial 1-bit result stream LSB-first into WIDTH-bit words and queues them in a
// DEPTH-entry first-word-fall-through FIFO. Define DROP_CNT_EN to add the drop_cnt output.
`timescale 1ns/1ps

module bit_pack_fifo #(
   parameter int unsigned WIDTH      = 8,
   parameter int unsigned DEPTH      = 123,
   parameter int unsigned DEPTH_BITS = $clog2(DEPTH),
   parameter int unsigned CNT_BITS   = $clog2(DEPTH + 1),
   parameter int unsigned LEN_BITS   = $clog2(WIDTH + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic                in_bit,
   input  logic                flush,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [WIDTH-1:0]    out_data,
   output logic [LEN_BITS-1:0] out_len,
   output logic [CNT_BITS-1:0] count,
   output logic                full,
`ifdef DROP_CNT_EN
   output logic [15:0]         drop_cnt,
`endif
   output logic                overflow
);

   localparam int unsigned EntryW = WIDTH + LEN_BITS;

   // ---------------------------------------------------------------------------------------------
   // Packer
   // ---------------------------------------------------------------------------------------------
   logic [WIDTH-1:0]    shreg_q, shreg_d;
   logic [LEN_BITS-1:0] idx_q, idx_d;
   logic [WIDTH-1:0]    merged;
   logic [LEN_BITS-1:0] push_len;
   logic                complete;
   logic                push;

   always_comb begin
      merged = shreg_q;
      if (in_valid) begin
         merged = shreg_q | (WIDTH'(in_bit) << idx_q);
      end
      // Bits already taken plus the one arriving now; equals WIDTH on a completing edge.
      push_len = idx_q + LEN_BITS'(in_valid);
      complete = in_valid && (idx_q == LEN_BITS'(WIDTH - 1));
      push     = complete || (flush && (push_len != '0));

      shreg_d = shreg_q;
      idx_d   = idx_q;
      if (push) begin
         shreg_d = '0;
         idx_d   = '0;
      end else if (in_valid) begin
         shreg_d = merged;
         idx_d   = idx_q + LEN_BITS'(1);
      end
   end

   // ---------------------------------------------------------------------------------------------
   // FIFO
   // ---------------------------------------------------------------------------------------------
   logic [EntryW-1:0]     mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_BITS-1:0]   count_q, count_d;
   logic                  overflow_q, overflow_d;
   logic                  pop;
   logic                  wr_en;
   logic                  drop;
   logic [EntryW-1:0]     rd_entry;

   function automatic logic [DEPTH_BITS-1:0] ptr_inc(input logic [DEPTH_BITS-1:0] p);
      return (p == DEPTH_BITS'(DEPTH - 1)) ? '0 : p + DEPTH_BITS'(1);
   endfunction

   assign out_valid = (count_q != '0);
   assign full      = (count_q == CNT_BITS'(DEPTH));
   assign count     = count_q;
   assign overflow  = overflow_q;

   always_comb begin
      pop   = out_valid && out_ready;
      // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
      wr_en = push && (!full || pop);
      drop  = push && full && !pop;

      wr_ptr_d   = wr_en ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      overflow_d = overflow_q | drop;

      count_d = count_q;
      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CNT_BITS'(1);
         2'b01:   count_d = count_q - CNT_BITS'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_q] <= {push_len, merged};
      end
   end

   // Storage is not reset, so the head is forced to zero while empty.
   always_comb begin
      rd_entry = mem[rd_ptr_q];
      out_data = '0;
      out_len  = '0;
      if (out_valid) begin
         out_data = rd_entry[WIDTH-1:0];
         out_len  = rd_entry[EntryW-1:WIDTH];
      end
   end

`ifdef DROP_CNT_EN
   logic [15:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg_q    <= '0;
         idx_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         shreg_q    <= shreg_d;
         idx_q      <= idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

endmodule

// File: tb/tb_bit_pack_fifo.sv
// Scoreboard bench for bit_pack_fifo: a bit-queue reference model predicts words, a monitor
// compares every popped word; occupancy and flags are compared every cycle.
`timescale 1ns/1ps

module tb_bit_pack_fifo;

   localparam int WIDTH    = 8;
   localparam int DEPTH    = 123;
   localparam int CNT_BITS = 7;
   localparam int LEN_BITS = 4;

   logic                clk;
   logic                rst;
   logic                in_valid;
   logic                in_bit;
   logic                flush;
   logic                out_valid;
   logic                out_ready;
   logic [WIDTH-1:0]    out_data;
   logic [LEN_BITS-1:0] out_len;
   logic [CNT_BITS-1:0] count;
   logic                full;
   logic                overflow;
`ifdef DROP_CNT_EN
   logic [15:0]         drop_cnt;
`endif

   bit_pack_fifo dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_bit    (in_bit),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_len   (out_len),
      .count     (count),
      .full      (full),
`ifdef DROP_CNT_EN
      .drop_cnt  (drop_cnt),
`endif
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int data;
      int len;
   } entry_t;

   entry_t exp_q[$];
   int     bits_q[$];
   int     model_cnt;
   int     model_ovf;
   int     model_drops;
   int     model_pushes;
   int     checks;
   int     passes;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) begin
         passes++;
      end else begin
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      bits_q.delete();
      model_cnt   = 0;
      model_ovf   = 0;
      model_drops = 0;
   endtask

   // Effect of one clock edge with the given inputs, from the behavioural rules.
   task automatic model_edge(input bit v, input bit b, input bit f, input bit r);
      bit     pop;
      entry_t e;
      pop = (model_cnt > 0) && r;
      if (v) bits_q.push_back(int'(b));
      if ((bits_q.size() == WIDTH) || (f && (bits_q.size() > 0))) begin
         e.data = 0;
         foreach (bits_q[k]) e.data = e.data | (bits_q[k] << k);
         e.len = bits_q.size();
         bits_q.delete();
         model_pushes++;
         if ((model_cnt < DEPTH) || pop) begin
            exp_q.push_back(e);
            model_cnt++;
         end else begin
            model_ovf = 1;
            if (model_drops < 65535) model_drops++;
         end
      end
      if (pop) model_cnt--;
   endtask

   task automatic check_state();
      chk("count", 32'(count), model_cnt);
      chk("out_valid", 32'(out_valid), 32'(model_cnt != 0));
      chk("full", 32'(full), 32'(model_cnt == DEPTH));
      chk("overflow", 32'(overflow), model_ovf);
`ifdef DROP_CNT_EN
      chk("drop_cnt", 32'(drop_cnt), model_drops);
`endif
   endtask

   task automatic step(input bit v, input bit b, input bit f, input bit r);
      @(posedge clk);
      #1;
      check_state();
      in_valid  = v;
      in_bit    = b;
      flush     = f;
      out_ready = r;
      model_edge(v, b, f, r);
   endtask

   task automatic push_word(input bit last_ready);
      for (int i = 0; i < WIDTH; i++) begin
         step(1'b1, 1'($urandom_range(0, 1)), 1'b0, (i == WIDTH - 1) ? last_ready : 1'b0);
      end
   endtask

   task automatic drain();
      for (int i = 0; (i < DEPTH + 8) && (model_cnt > 0); i++) step(1'b0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("scoreboard_empty", exp_q.size(), 0);
   endtask

   // Monitor: every accepted head word must match the oldest predicted word.
   initial begin
      entry_t e;
      forever begin
         @(negedge clk);
         if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("pop_when_model_empty", 32'(out_valid), 0);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), e.data);
               chk("out_len", 32'(out_len), e.len);
            end
         end
      end
   end

   initial begin
      int start;
      bit pattern [8];
      checks       = 0;
      passes       = 0;
      model_pushes = 0;
      model_reset();
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #3;
      rst = 1'b0;
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_data", 32'(out_data), 0);
      chk("rst_out_len", 32'(out_len), 0);
      chk("rst_count", 32'(count), 0);
      chk("rst_full", 32'(full), 0);
      chk("rst_overflow", 32'(overflow), 0);

      // Bit order: 1,0,1,1,0,0,1,0 packs LSB-first into 8'h4D.
      pattern = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) step(1'b1, pattern[i], 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("order_data", 32'(out_data), 32'h4D);
      chk("order_len", 32'(out_len), 8);
      chk("order_count", 32'(count), 1);
      step(1'b0, 1'b0, 1'b0, 1'b1);

      // Partial flush of three ones, then an empty flush that must not push.
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_data", 32'(out_data), 32'h07);
      chk("flush_len", 32'(out_len), 3);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("empty_flush_count", 32'(count), 1);
      // Flush coincident with a completing bit yields exactly one full word.
      for (int i = 0; i < WIDTH - 1; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("flush_complete_count", 32'(count), 2);
      drain();

      // Fill to full, then a completing edge with a simultaneous pop.
      for (int w = 0; w < DEPTH; w++) push_word(1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("fill_full", 32'(full), 1);
      chk("fill_count", 32'(count), DEPTH);
      push_word(1'b1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("pushpop_count", 32'(count), DEPTH);
      chk("pushpop_overflow", 32'(overflow), 0);
      drain();

      // Fill to full, then one dropped word.
      for (int w = 0; w < DEPTH + 1; w++) push_word(1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("ovf_set", 32'(overflow), 1);
      chk("ovf_count", 32'(count), DEPTH);
      drain();

      // Random traffic across several pointer wraps.
      start = model_pushes;
      for (int c = 0; (c < 20000) && (model_pushes - start < 300); c++) begin
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)));
      end
      drain();

      // Slow consumer: reaches full and drops words repeatedly.
      for (int c = 0; c < 1500; c++) begin
         step(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 15) == 0));
      end
      drain();

      // Asynchronous reset mid-word with four words queued.
      for (int w = 0; w < 4; w++) push_word(1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      flush    = 1'b0;
      rst      = 1'b1;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 0);
      chk("async_rst_count", 32'(count), 0);
      chk("async_rst_overflow", 32'(overflow), 0);
      model_reset();
      @(posedge clk);
      #3;
      rst = 1'b0;
      push_word(1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_len", 32'(out_len), 8);
      chk("post_rst_count", 32'(count), 1);
      drain();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
